// File: rtl/ripple_mon_pkg.sv
// Shared definitions for the ripple counter monitor: FSM encoding,
// event bit positions and default bus widths.
package ripple_mon_pkg;

    localparam int DEFAULT_WIDTH  = 6;
    localparam int DEFAULT_WRAP_W = 8;

    // Bit positions inside evt_type
    localparam int EVT_MATCH = 0;
    localparam int EVT_WRAP  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/count_stabilizer.sv
// Two-stage sampler for the rippling count bus. A value is reported as
// stable only when two consecutive samples agree, which rejects bits that
// were caught mid-ripple.
module count_stabilizer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] sample,
    output logic             stable
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    // Shift the raw bus through the two sample stages every cycle
    always_comb begin
        s1_d = count_in;
        s2_d = s1_q;
    end

    // Sample registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sample = s2_q;
    assign stable = (s1_q == s2_q);

endmodule

// File: rtl/ripple_count_monitor.sv
// Monitor for a ripple counter: accepts only stable samples, tracks the
// last accepted value, raises match/wrap events through a one-deep
// valid/ready register and keeps a saturating wrap tally.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int WRAP_W = DEFAULT_WRAP_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              enable,
    input  logic [WIDTH-1:0]  threshold,
    output logic [WIDTH-1:0]  stable_count,
    output logic              stable_valid,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_type,
    output logic [WIDTH-1:0]  evt_value,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              overrun
);

    logic [WIDTH-1:0] sample;
    logic             stable;

    count_stabilizer #(.WIDTH(WIDTH)) u_stabilizer (
        .clk      (clk),
        .clr      (clr),
        .count_in (count_in),
        .sample   (sample),
        .stable   (stable)
    );

    mon_state_e        state_q, state_d;
    logic [WIDTH-1:0]  stable_count_q, stable_count_d;
    logic              stable_valid_q, stable_valid_d;
    logic              evt_valid_q, evt_valid_d;
    logic [1:0]        evt_type_q, evt_type_d;
    logic [WIDTH-1:0]  evt_value_q, evt_value_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              overrun_q, overrun_d;

    logic              update;
    logic              match_hit;
    logic              wrap_hit;
    logic [1:0]        new_type;

    // Next-state logic: FSM, update detection, event register and wrap tally
    always_comb begin
        state_d        = state_q;
        stable_count_d = stable_count_q;
        stable_valid_d = stable_valid_q;
        evt_valid_d    = evt_valid_q;
        evt_type_d     = evt_type_q;
        evt_value_d    = evt_value_q;
        wrap_count_d   = wrap_count_q;
        overrun_d      = overrun_q;
        update         = 1'b0;
        new_type       = 2'b00;

        // Dropping enable returns to IDLE from anywhere; the held value stays
        if (!enable) begin
            state_d        = IDLE;
            stable_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stable_valid_d = 1'b0;
                    state_d        = ACQUIRE;
                end
                ACQUIRE: begin
                    if (stable) begin
                        stable_count_d = sample;
                        stable_valid_d = 1'b1;
                        state_d        = TRACK;
                    end
                end
                TRACK: begin
                    update = stable && (sample != stable_count_q);
                end
                default: begin
                    state_d        = IDLE;
                    stable_valid_d = 1'b0;
                end
            endcase
        end

        match_hit = update && (sample == threshold) && (stable_count_q != threshold);
        wrap_hit  = update && (sample < stable_count_q);
        new_type[EVT_MATCH] = match_hit;
        new_type[EVT_WRAP]  = wrap_hit;

        if (update) begin
            stable_count_d = sample;
        end

        if (wrap_hit && (wrap_count_q != {WRAP_W{1'b1}})) begin
            wrap_count_d = wrap_count_q + 1'b1;
        end

        // A consumer accept frees the slot in the same cycle a new event arrives
        if (match_hit || wrap_hit) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_type_d  = new_type;
                evt_value_d = sample;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q        <= IDLE;
            stable_count_q <= '0;
            stable_valid_q <= 1'b0;
            evt_valid_q    <= 1'b0;
            evt_type_q     <= 2'b00;
            evt_value_q    <= '0;
            wrap_count_q   <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            stable_count_q <= stable_count_d;
            stable_valid_q <= stable_valid_d;
            evt_valid_q    <= evt_valid_d;
            evt_type_q     <= evt_type_d;
            evt_value_q    <= evt_value_d;
            wrap_count_q   <= wrap_count_d;
            overrun_q      <= overrun_d;
        end
    end

    assign stable_count = stable_count_q;
    assign stable_valid = stable_valid_q;
    assign evt_valid    = evt_valid_q;
    assign evt_type     = evt_type_q;
    assign evt_value    = evt_value_q;
    assign wrap_count   = wrap_count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed testbench for ripple_count_monitor. Inputs change and outputs
// are observed on the falling clock edge.
module tb_ripple_count_monitor;

    logic       clk;
    logic       clr;
    logic [5:0] count_in;
    logic       enable;
    logic [5:0] threshold;
    logic [5:0] stable_count;
    logic       stable_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [5:0] evt_value;
    logic [7:0] wrap_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    ripple_count_monitor #(.WIDTH(6), .WRAP_W(8)) dut (
        .clk          (clk),
        .clr          (clr),
        .count_in     (count_in),
        .enable       (enable),
        .threshold    (threshold),
        .stable_count (stable_count),
        .stable_valid (stable_valid),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_type     (evt_type),
        .evt_value    (evt_value),
        .wrap_count   (wrap_count),
        .overrun      (overrun)
    );

    // Free-running system clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance by n falling edges
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Short asynchronous clear pulse between clock edges
    task automatic do_reset();
        enable    = 1'b0;
        evt_ready = 1'b0;
        clr       = 1'b1;
        #2;
        clr       = 1'b0;
        tick(1);
    endtask

    // All outputs must read zero while clr is held from power-up
    task automatic test_reset();
        #3;
        checks++;
        if ({stable_count, stable_valid, evt_valid, evt_type, evt_value, wrap_count, overrun} !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {stable_count, stable_valid, evt_valid, evt_type, evt_value, wrap_count, overrun});
        end
        @(negedge clk);
        clr = 1'b0;
        tick(1);
    endtask

    // Acquire 3, step through 4 and 5; 5 matches the threshold
    task automatic test_acquire_match();
        threshold = 6'd5;
        enable    = 1'b1;
        count_in  = 6'd3;
        tick(2);
        checks++;
        if (stable_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL acq_early_valid: got %b required 0", stable_valid);
        end
        tick(1);
        checks++;
        if (stable_valid !== 1'b1 || stable_count !== 6'd3) begin
            errors++;
            $display("[TB] FAIL acq_load: valid %b count %0d required 1 / 3", stable_valid, stable_count);
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL acq_no_event: got %b required 0", evt_valid);
        end
        tick(1);
        count_in = 6'd4;
        tick(3);
        checks++;
        if (stable_count !== 6'd4 || evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_4: count %0d evt %b required 4 / 0", stable_count, evt_valid);
        end
        tick(1);
        count_in = 6'd5;
        tick(2);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL match_early: got %b required 0", evt_valid);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 6'd5) begin
            errors++;
            $display("[TB] FAIL match_event: valid %b type %b value %0d required 1 / 01 / 5",
                     evt_valid, evt_type, evt_value);
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL match_accept: got %b required 0", evt_valid);
        end
    endtask

    // 5 -> 63 raises nothing; 63 -> 0 with threshold 0 is wrap and match
    task automatic test_wrap_match();
        threshold = 6'd0;
        count_in  = 6'd63;
        tick(3);
        checks++;
        if (stable_count !== 6'd63 || evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_63: count %0d evt %b required 63 / 0", stable_count, evt_valid);
        end
        count_in = 6'd0;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b11 || evt_value !== 6'd0 || wrap_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL wrap_match: valid %b type %b value %0d wraps %0d required 1 / 11 / 0 / 1",
                     evt_valid, evt_type, evt_value, wrap_count);
        end
        evt_ready = 1'b1;
        tick(1);
    endtask

    // One-sample glitch rejected; two-sample glitch accepted
    task automatic test_glitch();
        count_in = 6'd10;
        tick(3);
        threshold = 6'd14;
        checks++;
        if (stable_count !== 6'd10 || evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_base: count %0d evt %b required 10 / 0", stable_count, evt_valid);
        end
        count_in = 6'd14;
        tick(1);
        count_in = 6'd10;
        tick(4);
        checks++;
        if (stable_count !== 6'd10 || evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_reject: count %0d evt %b required 10 / 0", stable_count, evt_valid);
        end
        count_in = 6'd14;
        tick(2);
        count_in = 6'd10;
        tick(1);
        checks++;
        if (stable_count !== 6'd14 || evt_valid !== 1'b1 || evt_type !== 2'b01) begin
            errors++;
            $display("[TB] FAIL glitch_accept: count %0d evt %b type %b required 14 / 1 / 01",
                     stable_count, evt_valid, evt_type);
        end
        tick(2);
        checks++;
        if (stable_count !== 6'd10 || evt_type !== 2'b10 || evt_value !== 6'd10 || wrap_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL glitch_back: count %0d type %b value %0d wraps %0d required 10 / 10 / 10 / 2",
                     stable_count, evt_type, evt_value, wrap_count);
        end
        tick(1);
        evt_ready = 1'b0;
    endtask

    // Second event while the first is held is dropped and flags overrun
    task automatic test_backpressure();
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_start: evt %b overrun %b required 0 / 0", evt_valid, overrun);
        end
        count_in = 6'd14;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 6'd14) begin
            errors++;
            $display("[TB] FAIL bp_first: valid %b type %b value %0d required 1 / 01 / 14",
                     evt_valid, evt_type, evt_value);
        end
        count_in = 6'd2;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 6'd14 || overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_drop: valid %b type %b value %0d overrun %b required 1 / 01 / 14 / 1",
                     evt_valid, evt_type, evt_value, overrun);
        end
        checks++;
        if (stable_count !== 6'd2 || wrap_count !== 8'd3) begin
            errors++;
            $display("[TB] FAIL bp_tally: count %0d wraps %0d required 2 / 3", stable_count, wrap_count);
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: evt %b overrun %b required 0 / 1", evt_valid, overrun);
        end
    endtask

    // Accept and new event on the same edge; then the enable drop
    task automatic test_back_to_back();
        do_reset();
        threshold = 6'd30;
        enable    = 1'b1;
        count_in  = 6'd10;
        tick(4);
        count_in = 6'd30;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 6'd30) begin
            errors++;
            $display("[TB] FAIL b2b_first: valid %b type %b value %0d required 1 / 01 / 30",
                     evt_valid, evt_type, evt_value);
        end
        count_in = 6'd5;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b10 || evt_value !== 6'd5 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_reload: valid %b type %b value %0d overrun %b required 1 / 10 / 5 / 0",
                     evt_valid, evt_type, evt_value, overrun);
        end
        enable = 1'b0;
        tick(1);
        checks++;
        if (stable_valid !== 1'b0 || evt_valid !== 1'b1 || stable_count !== 6'd5) begin
            errors++;
            $display("[TB] FAIL enable_drop: valid %b evt %b count %0d required 0 / 1 / 5",
                     stable_valid, evt_valid, stable_count);
        end
    endtask

    // Asynchronous clear in TRACK with a pending event, then restart from IDLE
    task automatic test_clear_mid_track();
        do_reset();
        threshold = 6'd7;
        enable    = 1'b1;
        count_in  = 6'd20;
        tick(4);
        count_in = 6'd7;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b11 || wrap_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL clr_setup: valid %b type %b wraps %0d required 1 / 11 / 1",
                     evt_valid, evt_type, wrap_count);
        end
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if ({stable_count, stable_valid, evt_valid, evt_type, evt_value, wrap_count, overrun} !== 24'd0) begin
            errors++;
            $display("[TB] FAIL clr_async: got %h required 0",
                     {stable_count, stable_valid, evt_valid, evt_type, evt_value, wrap_count, overrun});
        end
        #1;
        clr = 1'b0;
        tick(1);
        checks++;
        if (stable_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_idle: got %b required 0", stable_valid);
        end
        tick(2);
        checks++;
        if (stable_valid !== 1'b1 || stable_count !== 6'd7 || evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_reacquire: valid %b count %0d evt %b required 1 / 7 / 0",
                     stable_valid, stable_count, evt_valid);
        end
    endtask

    // 260 wraps of 40 -> 20; tally saturates at 255, events keep coming
    task automatic test_saturation();
        int exp_wraps;
        do_reset();
        threshold = 6'd0;
        enable    = 1'b1;
        evt_ready = 1'b1;
        count_in  = 6'd40;
        tick(4);
        for (int i = 0; i < 260; i++) begin
            exp_wraps = (i + 1 > 255) ? 255 : i + 1;
            count_in = 6'd20;
            tick(2);
            count_in = 6'd40;
            tick(1);
            checks++;
            if (evt_valid !== 1'b1 || evt_type !== 2'b10 || evt_value !== 6'd20 ||
                wrap_count !== exp_wraps[7:0]) begin
                errors++;
                $display("[TB] FAIL sat_wrap_%0d: valid %b type %b value %0d wraps %0d required 1 / 10 / 20 / %0d",
                         i, evt_valid, evt_type, evt_value, wrap_count, exp_wraps);
            end
            tick(1);
        end
        checks++;
        if (wrap_count !== 8'd255 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_final: wraps %0d overrun %b required 255 / 0", wrap_count, overrun);
        end
    endtask

    initial begin
        clr       = 1'b1;
        enable    = 1'b0;
        count_in  = 6'd0;
        threshold = 6'd0;
        evt_ready = 1'b0;
        test_reset();
        test_acquire_match();
        test_wrap_match();
        test_glitch();
        test_backpressure();
        test_back_to_back();
        test_clear_mid_track();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
